// File: rtl/jt5205_adpcm_mc.sv
// Multi-channel OKI MSM5205-style ADPCM decoder. One serial shift-add datapath
// is time-shared across CHANNELS nibble streams; 4-bit or 3-bit sample modes.
module jt5205_adpcm_mc #(
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned OUT_W    = 12,
  parameter bit          SATURATE = 1'b1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      cen_hf,
  input  logic                      cen_lo,
  input  logic                      mode4,
  input  logic [4*CHANNELS-1:0]     din,
  input  logic [CHANNELS-1:0]       chan_rst,
  output logic [OUT_W*CHANNELS-1:0] sound,
  output logic                      busy,
  output logic                      overrun
);

  localparam int unsigned CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int unsigned IDX_W = 6;
  localparam int unsigned D_W   = 11;
  localparam int unsigned Q_W   = 12;
  // Two guard bits: |acc| + q_max can exceed the OUT_W+1 signed range.
  localparam int unsigned SUM_W = OUT_W + 2;
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(48);

  typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_ADD, ST_UPDATE} state_t;

  state_t                  state_q, state_d;
  logic [CH_W-1:0]         ch_q;
  logic [D_W-1:0]          d_q;
  logic [Q_W-1:0]          q_q;
  logic [2:0]              sr_q;
  logic [1:0]              cnt_q;
  logic [4*CHANNELS-1:0]   din_q;
  logic                    mode_q;
  logic signed [OUT_W-1:0] acc_q [CHANNELS];
  logic [IDX_W-1:0]        idx_q [CHANNELS];

  logic                    tick_c;
  logic                    upd_c;
  logic [3:0]              nib_c;
  logic                    sign_c;
  logic [2:0]              mag_c;
  logic signed [7:0]       adj_c;
  logic [D_W-1:0]          delta_c;
  logic signed [OUT_W-1:0] acc_cur_c;
  logic signed [SUM_W-1:0] acc_ext_c;
  logic signed [SUM_W-1:0] q_ext_c;
  logic signed [SUM_W-1:0] sum_c;
  logic signed [OUT_W-1:0] acc_nx_c;
  logic signed [7:0]       idx_sum_c;
  logic [IDX_W-1:0]        idx_nx_c;

  // Step-size table, 49 entries; indices above 48 are never reached.
  function automatic logic [D_W-1:0] delta_lut(input logic [IDX_W-1:0] i);
    case (i)
      6'd0:  delta_lut = 11'd16;   6'd1:  delta_lut = 11'd17;   6'd2:  delta_lut = 11'd19;
      6'd3:  delta_lut = 11'd21;   6'd4:  delta_lut = 11'd23;   6'd5:  delta_lut = 11'd25;
      6'd6:  delta_lut = 11'd28;   6'd7:  delta_lut = 11'd31;   6'd8:  delta_lut = 11'd34;
      6'd9:  delta_lut = 11'd37;   6'd10: delta_lut = 11'd41;   6'd11: delta_lut = 11'd45;
      6'd12: delta_lut = 11'd50;   6'd13: delta_lut = 11'd55;   6'd14: delta_lut = 11'd60;
      6'd15: delta_lut = 11'd66;   6'd16: delta_lut = 11'd73;   6'd17: delta_lut = 11'd80;
      6'd18: delta_lut = 11'd88;   6'd19: delta_lut = 11'd97;   6'd20: delta_lut = 11'd107;
      6'd21: delta_lut = 11'd118;  6'd22: delta_lut = 11'd130;  6'd23: delta_lut = 11'd143;
      6'd24: delta_lut = 11'd157;  6'd25: delta_lut = 11'd173;  6'd26: delta_lut = 11'd190;
      6'd27: delta_lut = 11'd209;  6'd28: delta_lut = 11'd230;  6'd29: delta_lut = 11'd253;
      6'd30: delta_lut = 11'd279;  6'd31: delta_lut = 11'd307;  6'd32: delta_lut = 11'd337;
      6'd33: delta_lut = 11'd371;  6'd34: delta_lut = 11'd408;  6'd35: delta_lut = 11'd449;
      6'd36: delta_lut = 11'd494;  6'd37: delta_lut = 11'd544;  6'd38: delta_lut = 11'd598;
      6'd39: delta_lut = 11'd658;  6'd40: delta_lut = 11'd724;  6'd41: delta_lut = 11'd796;
      6'd42: delta_lut = 11'd876;  6'd43: delta_lut = 11'd963;  6'd44: delta_lut = 11'd1060;
      6'd45: delta_lut = 11'd1166; 6'd46: delta_lut = 11'd1282; 6'd47: delta_lut = 11'd1411;
      default: delta_lut = 11'd1552;
    endcase
  endfunction

  // Decode the current channel's nibble and form the next acc/idx values.
  always_comb begin
    tick_c = cen_hf & ~cen_lo;
    upd_c  = tick_c & (state_q == ST_UPDATE);
    nib_c  = din_q[{ch_q, 2'b00} +: 4];
    if (mode_q) begin
      sign_c = nib_c[3];
      mag_c  = nib_c[2:0];
    end else begin
      sign_c = nib_c[2];
      mag_c  = {nib_c[1:0], 1'b0};
    end
    adj_c = -8'sd1;
    if (mag_c[2]) begin
      if (mode_q) adj_c = $signed({5'd0, mag_c[1:0], 1'b0}) + 8'sd2;
      else        adj_c = mag_c[1] ? 8'sd4 : 8'sd2;
    end
    delta_c   = delta_lut(idx_q[ch_q]);
    acc_cur_c = acc_q[ch_q];
    acc_ext_c = {{(SUM_W-OUT_W){acc_cur_c[OUT_W-1]}}, acc_cur_c};
    q_ext_c   = {{(SUM_W-Q_W){1'b0}}, q_q};
    sum_c     = sign_c ? (acc_ext_c - q_ext_c) : (acc_ext_c + q_ext_c);
    if (SATURATE && (sum_c[SUM_W-1:OUT_W-1] != '0) && (sum_c[SUM_W-1:OUT_W-1] != '1))
      acc_nx_c = sum_c[SUM_W-1] ? {1'b1, {(OUT_W-1){1'b0}}} : {1'b0, {(OUT_W-1){1'b1}}};
    else
      acc_nx_c = sum_c[OUT_W-1:0];
    idx_sum_c = $signed({2'b00, idx_q[ch_q]}) + adj_c;
    if (idx_sum_c < 8'sd0)       idx_nx_c = '0;
    else if (idx_sum_c > 8'sd48) idx_nx_c = IDX_MAX;
    else                         idx_nx_c = idx_sum_c[IDX_W-1:0];
  end

  // Next-state logic: cen_lo restarts the sweep, cen_hf advances it.
  always_comb begin
    state_d = state_q;
    if (cen_lo) begin
      state_d = ST_LOAD;
    end else if (cen_hf) begin
      case (state_q)
        ST_IDLE:   state_d = ST_IDLE;
        ST_LOAD:   state_d = ST_ADD;
        ST_ADD:    if (cnt_q == 2'd1) state_d = ST_UPDATE;
        ST_UPDATE: state_d = (ch_q == CH_W'(CHANNELS-1)) ? ST_IDLE : ST_LOAD;
        default:   state_d = ST_IDLE;
      endcase
    end
  end

  // State register with registered busy/overrun flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      busy    <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state_q <= state_d;
      busy    <= (state_d != ST_IDLE);
      overrun <= cen_lo & (state_q != ST_IDLE);
    end
  end

  // Sample latch, output update and shift-add multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_q   <= '0;
      d_q    <= '0;
      q_q    <= '0;
      sr_q   <= '0;
      cnt_q  <= '0;
      din_q  <= '0;
      mode_q <= 1'b0;
      sound  <= '0;
    end else if (cen_lo) begin
      ch_q   <= '0;
      din_q  <= din;
      mode_q <= mode4;
      for (int n = 0; n < CHANNELS; n++) sound[OUT_W*n +: OUT_W] <= acc_q[n];
    end else if (cen_hf) begin
      case (state_q)
        ST_LOAD: begin
          d_q   <= delta_c;
          q_q   <= mode_q ? Q_W'(delta_c >> 3) : Q_W'(delta_c >> 2);
          sr_q  <= mag_c;
          cnt_q <= mode_q ? 2'd3 : 2'd2;
        end
        ST_ADD: begin
          if (sr_q[2]) q_q <= q_q + Q_W'(d_q);
          d_q   <= d_q >> 1;
          sr_q  <= {sr_q[1:0], 1'b0};
          cnt_q <= cnt_q - 2'd1;
        end
        ST_UPDATE: ch_q <= ch_q + CH_W'(1);
        default: ;
      endcase
    end
  end

  // Per-channel predictor state; chan_rst wins over a same-cycle update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int n = 0; n < CHANNELS; n++) begin
        acc_q[n] <= '0;
        idx_q[n] <= '0;
      end
    end else begin
      for (int n = 0; n < CHANNELS; n++) begin
        if (chan_rst[n]) begin
          acc_q[n] <= '0;
          idx_q[n] <= '0;
        end else if (upd_c && (ch_q == CH_W'(n))) begin
          acc_q[n] <= acc_nx_c;
          idx_q[n] <= idx_nx_c;
        end
      end
    end
  end

endmodule
